// File: rtl/constants.sv
// Shared constants for the multi-cycle execution scheduler: FSM state
// encoding, default unit latencies and the writeback unit codes.
package constants;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int DEFAULT_MUL_LAT   = 3;
  localparam int DEFAULT_DIV_LAT   = 33;
  localparam int DEFAULT_CLMUL_LAT = 33;

  // Counter wide enough for LAT-1 with LAT up to 64.
  localparam int CNT_W = 6;

  localparam logic [1:0] UNIT_MUL   = 2'd0;
  localparam logic [1:0] UNIT_DIV   = 2'd1;
  localparam logic [1:0] UNIT_CLMUL = 2'd2;

endpackage

// File: rtl/wires.sv
// Bundled views of the scheduler's inputs and outputs, used inside the top
// level to keep the datapath readable.
package wires;

  typedef struct packed {
    logic       issue_valid;
    logic       issue_mult;
    logic       issue_division;
    logic       issue_bitc;
    logic [4:0] issue_waddr;
    logic       issue_wren;
    logic       flush;
    logic       rden1;
    logic       rden2;
    logic [4:0] raddr1;
    logic [4:0] raddr2;
    logic       wb_ready;
  } exec_sched_in_type;

  typedef struct packed {
    logic       issue_ready;
    logic [2:0] unit_start;
    logic       unit_kill;
    logic       hazard;
    logic       stall;
    logic       wb_valid;
    logic [1:0] wb_unit;
    logic [4:0] wb_waddr;
    logic       wb_wren;
    logic       err;
  } exec_sched_out_type;

endpackage

// File: rtl/exec_hazard.sv
// Read-after-write check of the younger instruction's sources against the
// destination of the operation currently in flight.
module exec_hazard (
  input  logic       active_i,
  input  logic       wren_i,
  input  logic [4:0] waddr_i,
  input  logic       rden1_i,
  input  logic [4:0] raddr1_i,
  input  logic       rden2_i,
  input  logic [4:0] raddr2_i,
  output logic       hazard_o
);

  // A hit on either enabled read port stalls the younger instruction.
  assign hazard_o = active_i & wren_i &
                    ((rden1_i & (raddr1_i == waddr_i)) |
                     (rden2_i & (raddr2_i == waddr_i)));

endmodule

// File: rtl/exec_sched.sv
// Scheduler for one outstanding multi-cycle operation (mul, div, clmul):
// accepts an issue, times the unit latency, presents the result for
// writeback and reports hazards for younger reads.
module exec_sched
  import constants::*;
  import wires::*;
#(
  parameter int MUL_LAT   = DEFAULT_MUL_LAT,
  parameter int DIV_LAT   = DEFAULT_DIV_LAT,
  parameter int CLMUL_LAT = DEFAULT_CLMUL_LAT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_mult,
  input  logic       issue_division,
  input  logic       issue_bitc,
  input  logic [4:0] issue_waddr,
  input  logic       issue_wren,
  output logic       issue_ready,
  input  logic       flush,
  input  logic       rden1,
  input  logic       rden2,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output logic [2:0] unit_start,
  output logic       unit_kill,
  output logic       hazard,
  output logic       stall,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [1:0] wb_unit,
  output logic [4:0] wb_waddr,
  output logic       wb_wren,
  output logic       err
);

  localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CLMUL_CNT = CNT_W'(CLMUL_LAT - 1);

  exec_sched_in_type  in_s;
  exec_sched_out_type out_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       unit_q, unit_d;
  logic [4:0]       waddr_q, waddr_d;
  logic             wren_q, wren_d;

  logic             ready;
  logic             one_flag;
  logic             offered;
  logic             accept;
  logic [1:0]       sel_unit;
  logic [CNT_W-1:0] sel_cnt;
  logic             hazard_w;

  assign in_s = '{
    issue_valid:    issue_valid,
    issue_mult:     issue_mult,
    issue_division: issue_division,
    issue_bitc:     issue_bitc,
    issue_waddr:    issue_waddr,
    issue_wren:     issue_wren,
    flush:          flush,
    rden1:          rden1,
    rden2:          rden2,
    raddr1:         raddr1,
    raddr2:         raddr2,
    wb_ready:       wb_ready
  };

  // Issue handshake: idle, or draining WB this cycle without a flush. A
  // flush blocks acceptance in every state; reset blocks all pulses.
  always_comb begin
    ready    = (state_q == ST_IDLE) |
               ((state_q == ST_WB) & in_s.wb_ready & ~in_s.flush);
    one_flag = $onehot({in_s.issue_bitc, in_s.issue_division, in_s.issue_mult});
    offered  = in_s.issue_valid & ready & ~reset;
    accept   = offered & one_flag & ~in_s.flush;
  end

  // Unit code and counter preload for the flagged unit.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    sel_unit = UNIT_MUL;
    sel_cnt  = MUL_CNT;
    if (in_s.issue_division) begin
      sel_unit = UNIT_DIV;
      sel_cnt  = DIV_CNT;
    end else if (in_s.issue_bitc) begin
      sel_unit = UNIT_CLMUL;
      sel_cnt  = CLMUL_CNT;
    end
  end

  // Next-state logic: count down in RUN, hold in WB until drained, and drop
  // everything on a flush once an operation is in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unit_d  = unit_q;
    waddr_d = waddr_q;
    wren_d  = wren_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (in_s.flush)          state_d = ST_IDLE;
        else if (cnt_q == '0)    state_d = ST_WB;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      ST_WB: begin
        if (in_s.flush)          state_d = ST_IDLE;
        else if (in_s.wb_ready)  state_d = ST_IDLE;
      end
      default:                   state_d = ST_IDLE;
    endcase
    // Acceptance is only possible from IDLE or a draining WB, so it can
    // override whatever the case above chose.
    if (accept) begin
      state_d = ST_RUN;
      cnt_d   = sel_cnt;
      unit_d  = sel_unit;
      waddr_d = in_s.issue_waddr;
      wren_d  = in_s.issue_wren;
    end
  end

  // State and latched-operation registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      unit_q  <= UNIT_MUL;
      waddr_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      waddr_q <= waddr_d;
      wren_q  <= wren_d;
    end
  end

  exec_hazard u_hazard (
    .active_i (state_q != ST_IDLE),
    .wren_i   (wren_q),
    .waddr_i  (waddr_q),
    .rden1_i  (in_s.rden1),
    .raddr1_i (in_s.raddr1),
    .rden2_i  (in_s.rden2),
    .raddr2_i (in_s.raddr2),
    .hazard_o (hazard_w)
  );

  // Output bundle: start/kill/err are single-cycle pulses, wb_* reflect the
  // latched operation.
  always_comb begin
    out_s             = '0;
    out_s.issue_ready = ready;
    out_s.unit_start  = accept ? {in_s.issue_bitc, in_s.issue_division, in_s.issue_mult}
                               : 3'b000;
    out_s.unit_kill   = in_s.flush & (state_q != ST_IDLE) & ~reset;
    out_s.hazard      = hazard_w;
    out_s.stall       = in_s.issue_valid & ~ready;
    out_s.wb_valid    = (state_q == ST_WB);
    out_s.wb_unit     = unit_q;
    out_s.wb_waddr    = waddr_q;
    out_s.wb_wren     = wren_q;
    out_s.err         = offered & ~one_flag;
  end

  assign issue_ready = out_s.issue_ready;
  assign unit_start  = out_s.unit_start;
  assign unit_kill   = out_s.unit_kill;
  assign hazard      = out_s.hazard;
  assign stall       = out_s.stall;
  assign wb_valid    = out_s.wb_valid;
  assign wb_unit     = out_s.wb_unit;
  assign wb_waddr    = out_s.wb_waddr;
  assign wb_wren     = out_s.wb_wren;
  assign err         = out_s.err;

endmodule

// File: tb/tb_exec_sched.sv
// Self-checking bench for exec_sched: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a timestamp model.
module tb_exec_sched;

  localparam int MUL_LAT   = 3;
  localparam int DIV_LAT   = 33;
  localparam int CLMUL_LAT = 33;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid, issue_mult, issue_division, issue_bitc;
  logic [4:0] issue_waddr;
  logic       issue_wren;
  logic       issue_ready;
  logic       flush;
  logic       rden1, rden2;
  logic [4:0] raddr1, raddr2;
  logic [2:0] unit_start;
  logic       unit_kill, hazard, stall, wb_valid, wb_ready;
  logic [1:0] wb_unit;
  logic [4:0] wb_waddr;
  logic       wb_wren, err;

  int n_checks = 0;
  int n_err    = 0;

  exec_sched #(
    .MUL_LAT   (MUL_LAT),
    .DIV_LAT   (DIV_LAT),
    .CLMUL_LAT (CLMUL_LAT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_mult     (issue_mult),
    .issue_division (issue_division),
    .issue_bitc     (issue_bitc),
    .issue_waddr    (issue_waddr),
    .issue_wren     (issue_wren),
    .issue_ready    (issue_ready),
    .flush          (flush),
    .rden1          (rden1),
    .rden2          (rden2),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .unit_start     (unit_start),
    .unit_kill      (unit_kill),
    .hazard         (hazard),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_unit        (wb_unit),
    .wb_waddr       (wb_waddr),
    .wb_wren        (wb_wren),
    .err            (err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output packing: {ready, start[2:0], kill, hazard, stall, wbv, unit[1:0], waddr[4:0], wren, err}
  function automatic logic [16:0] pack(input logic ir, input logic [2:0] us, input logic uk,
                                       input logic hz, input logic st, input logic wv,
                                       input logic [1:0] wu, input logic [4:0] wa,
                                       input logic ww, input logic er);
    return {ir, us, uk, hz, st, wv, wu, wa, ww, er};
  endfunction

  function automatic logic [16:0] dut_vec();
    return pack(issue_ready, unit_start, unit_kill, hazard, stall, wb_valid,
                wb_unit, wb_waddr, wb_wren, err);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_mult = 1'b0; issue_division = 1'b0; issue_bitc = 1'b0;
    issue_waddr = 5'd0; issue_wren = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    rden1 = 1'b0; raddr1 = 5'd0; rden2 = 1'b0; raddr2 = 5'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic mu, input logic dv, input logic bc,
                       input logic [4:0] wa, input logic we);
    issue_valid = 1'b1; issue_mult = mu; issue_division = dv; issue_bitc = bc;
    issue_waddr = wa; issue_wren = we;
  endtask

  // Waits (bounded) for wb_valid; leaves the bench at the negedge of the
  // first WB cycle. exp_n is the number of clock edges expected on the way.
  task automatic wait_wb(input string name, input int exp_n);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock);
      if (wb_valid === 1'b1) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check({name, " seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, n, exp_n);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       iv, mu, dv, bc;
    logic [4:0] wa;
    logic       we, fl, wbr, r1;
    logic [4:0] a1;
    logic       r2;
    logic [4:0] a2;
    logic [16:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic mu, input logic dv, input logic bc,
                              input logic [4:0] wa, input logic we, input logic fl,
                              input logic wbr, input logic r1, input logic [4:0] a1,
                              input logic r2, input logic [4:0] a2, input logic [16:0] e);
    vec_t v;
    v.iv = iv; v.mu = mu; v.dv = dv; v.bc = bc; v.wa = wa; v.we = we; v.fl = fl;
    v.wbr = wbr; v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    issue_valid = v.iv; issue_mult = v.mu; issue_division = v.dv; issue_bitc = v.bc;
    issue_waddr = v.wa; issue_wren = v.we; flush = v.fl; wb_ready = v.wbr;
    rden1 = v.r1; raddr1 = v.a1; rden2 = v.r2; raddr2 = v.a2;
  endtask

  // ---------------- behavioural reference model ----------------
  // The in-flight op is remembered by its accept timestamp; its phase is
  // derived from elapsed cycles against the unit latency.
  bit         m_pend  = 1'b0;
  int         m_acc   = 0;
  int         m_lat   = 0;
  int         cyc     = 0;
  logic [1:0] m_unit  = 2'd0;
  logic [4:0] m_waddr = 5'd0;
  logic       m_wren  = 1'b0;

  task automatic model_cycle(input bit do_check);
    bit idle, in_wb, rdy, ok;
    int nflags;
    logic [2:0] st;
    logic hz;
    logic [16:0] e;
    idle   = !m_pend;
    in_wb  = m_pend && (cyc >= m_acc + m_lat + 1);
    rdy    = idle || (in_wb && wb_ready && !flush);
    nflags = int'(issue_mult) + int'(issue_division) + int'(issue_bitc);
    ok     = issue_valid && rdy && nflags == 1 && !flush;
    st     = ok ? {issue_bitc, issue_division, issue_mult} : 3'b000;
    hz     = !idle && m_wren && ((rden1 && raddr1 == m_waddr) || (rden2 && raddr2 == m_waddr));
    e = pack(rdy, st, !idle && flush, hz, issue_valid && !rdy, in_wb, m_unit, m_waddr,
             m_wren, issue_valid && rdy && nflags != 1);
    if (do_check) check($sformatf("random cyc%0d", cyc), dut_vec(), e);
    if (reset) begin
      m_pend = 1'b0; m_unit = 2'd0; m_waddr = 5'd0; m_wren = 1'b0;
    end else if (!idle && flush) begin
      m_pend = 1'b0;
    end else if (ok) begin
      m_pend  = 1'b1;
      m_acc   = cyc;
      m_unit  = issue_bitc ? 2'd2 : (issue_division ? 2'd1 : 2'd0);
      m_lat   = issue_bitc ? CLMUL_LAT : (issue_division ? DIV_LAT : MUL_LAT);
      m_waddr = issue_waddr;
      m_wren  = issue_wren;
    end else if (in_wb && wb_ready) begin
      m_pend = 1'b0;
    end
    cyc++;
  endtask

  vec_t vecs[22];

  initial begin
    // in: iv mu dv bc wa we fl wbr r1 a1 r2 a2 ; out: pack(...)
    vecs[0]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd0,'0,'0));
    vecs[1]  = mk('1,'1,'1,'0,5'd3,'1,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd0,'0,'1));
    vecs[2]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd0,'0,'0));
    vecs[3]  = mk('1,'1,'0,'0,5'd5,'1,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b001,'0,'0,'0,'0,2'd0,5'd0,'0,'0));
    vecs[4]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'1,5'd5,'0,5'd0, pack('0,3'b000,'0,'1,'0,'0,2'd0,5'd5,'1,'0));
    vecs[5]  = mk('1,'0,'1,'0,5'd6,'1,'0,'0,'1,5'd4,'0,5'd0, pack('0,3'b000,'0,'0,'1,'0,2'd0,5'd5,'1,'0));
    vecs[6]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'1,5'd5, pack('0,3'b000,'0,'1,'0,'0,2'd0,5'd5,'1,'0));
    vecs[7]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'0,5'd0, pack('0,3'b000,'0,'0,'0,'1,2'd0,5'd5,'1,'0));
    vecs[8]  = mk('0,'0,'0,'0,5'd0,'0,'0,'1,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'1,2'd0,5'd5,'1,'0));
    vecs[9]  = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'1,5'd5,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd5,'1,'0));
    vecs[10] = mk('1,'0,'0,'1,5'd7,'1,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b100,'0,'0,'0,'0,2'd0,5'd5,'1,'0));
    vecs[11] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'1,5'd7, pack('0,3'b000,'0,'1,'0,'0,2'd2,5'd7,'1,'0));
    vecs[12] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'1,5'd8, pack('0,3'b000,'0,'0,'0,'0,2'd2,5'd7,'1,'0));
    vecs[13] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'1,5'd7,'0,5'd0, pack('0,3'b000,'0,'1,'0,'0,2'd2,5'd7,'1,'0));
    vecs[14] = mk('0,'0,'0,'0,5'd0,'0,'1,'0,'0,5'd0,'0,5'd0, pack('0,3'b000,'1,'0,'0,'0,2'd2,5'd7,'1,'0));
    vecs[15] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'1,5'd7, pack('1,3'b000,'0,'0,'0,'0,2'd2,5'd7,'1,'0));
    vecs[16] = mk('1,'1,'0,'0,5'd7,'0,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b001,'0,'0,'0,'0,2'd2,5'd7,'1,'0));
    vecs[17] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'1,5'd7,'0,5'd0, pack('0,3'b000,'0,'0,'0,'0,2'd0,5'd7,'0,'0));
    vecs[18] = mk('0,'0,'0,'0,5'd0,'0,'1,'0,'0,5'd0,'0,5'd0, pack('0,3'b000,'1,'0,'0,'0,2'd0,5'd7,'0,'0));
    vecs[19] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd7,'0,'0));
    vecs[20] = mk('1,'1,'0,'0,5'd11,'1,'1,'0,'0,5'd0,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd7,'0,'0));
    vecs[21] = mk('0,'0,'0,'0,5'd0,'0,'0,'0,'1,5'd11,'0,5'd0, pack('1,3'b000,'0,'0,'0,'0,2'd0,5'd7,'0,'0));

    do_reset();
    for (int i = 0; i < 22; i++) begin
      apply(vecs[i]);
      @(negedge clock);
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
      tick();
    end

    // Div result held while wb_ready is low, pending issue stalls, then is
    // accepted on the wb_ready cycle and the new mul completes on time.
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 5'd9, 1'b1);
    @(negedge clock);
    check("div start", unit_start, 3'b010);
    tick();
    clear_inputs();
    wait_wb("div", DIV_LAT);
    check("div wb fields", {wb_unit, wb_waddr, wb_wren}, {2'd1, 5'd9, 1'b1});
    tick();
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
      wb_ready = 1'b0;
      @(negedge clock);
      check($sformatf("wb hold %0d", i),
            {wb_valid, wb_unit, wb_waddr, wb_wren, stall, issue_ready, unit_start},
            {1'b1, 2'd1, 5'd9, 1'b1, 1'b1, 1'b0, 3'b000});
      tick();
    end
    wb_ready = 1'b1;
    @(negedge clock);
    check("accept on wb_ready", {issue_ready, stall, unit_start, wb_valid},
          {1'b1, 1'b0, 3'b001, 1'b1});
    tick();
    clear_inputs();
    @(negedge clock);
    check("back to run", {wb_valid, issue_ready, wb_unit, wb_waddr}, {1'b0, 1'b0, 2'd0, 5'd2});
    tick();
    wait_wb("mul after div", MUL_LAT - 1);
    wb_ready = 1'b1;
    tick();
    clear_inputs();

    // Flush in the third RUN cycle of a div.
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    tick();
    clear_inputs();
    tick();
    tick();
    flush = 1'b1;
    @(negedge clock);
    check("flush kill", {unit_kill, issue_ready, wb_valid}, {1'b1, 1'b0, 1'b0});
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("idle after flush", {issue_ready, unit_kill, wb_valid}, {1'b1, 1'b0, 1'b0});
    begin
      bit seen_wb;
      seen_wb = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        @(negedge clock);
        if (wb_valid === 1'b1) seen_wb = 1'b1;
      end
      check("no wb after flush", 32'(seen_wb), 32'd0);
    end
    tick();

    // Flush wins over wb_ready in WB; the offered issue is refused.
    do_reset();
    issue(1'b1, 1'b0, 1'b0, 5'd12, 1'b1);
    tick();
    clear_inputs();
    wait_wb("mul", MUL_LAT);
    flush = 1'b1;
    wb_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 5'd13, 1'b1);
    #1;
    check("flush over wb_ready", {issue_ready, unit_kill, unit_start, wb_valid},
          {1'b0, 1'b1, 3'b000, 1'b1});
    tick();
    clear_inputs();
    @(negedge clock);
    check("idle after wb flush", {wb_valid, issue_ready, wb_waddr}, {1'b0, 1'b1, 5'd12});
    tick();

    // Reset while in WB.
    issue(1'b1, 1'b0, 1'b0, 5'd20, 1'b1);
    tick();
    clear_inputs();
    wait_wb("mul before reset", MUL_LAT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("after reset in wb", dut_vec(), pack('1, 3'b000, '0, '0, '0, '0, 2'd0, 5'd0, '0, '0));
    tick();

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = (n == 0) || ($urandom_range(0, 249) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      issue_mult     = (r <= 2) || (r == 8);
      issue_division = (r >= 3 && r <= 5) || (r == 8);
      issue_bitc     = (r == 6) || (r == 7);
      issue_waddr = 5'($urandom_range(0, 7));
      issue_wren  = $urandom_range(0, 3) != 0;
      flush       = $urandom_range(0, 29) == 0;
      wb_ready    = $urandom_range(0, 1) == 1;
      rden1  = $urandom_range(0, 1) == 1;
      rden2  = $urandom_range(0, 1) == 1;
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      @(negedge clock);
      model_cycle(!reset);
      tick();
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_sched.md
EXEC_SCHED -- requirements
Module: exec_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, multiplier latency in cycles (legal 1..64).
REQ-002 SHALL have parameter DIV_LAT, default 33, divider latency in cycles (legal 1..64).
REQ-003 SHALL have parameter CLMUL_LAT, default 33, carry-less multiplier latency in cycles (legal 1..64).
REQ-004 SHALL have ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decoded multi-cycle op offered.
- issue_mult / issue_division / issue_bitc  in  1 each  decoder unit flags.
- issue_waddr  in  5  destination register.
- issue_wren  in  1  destination write enable; already 0 for x0.
- issue_ready  out  1  op accepted this cycle.
- flush  in  1  pipeline kill.
- rden1, rden2  in  1 each  younger-instruction read enables.
- raddr1, raddr2  in  5 each  younger-instruction source registers.
- unit_start  out  3  one-hot start pulse {clmul, div, mul}.
- unit_kill  out  1  abort pulse to all units.
- hazard  out  1  younger read hits the pending destination.
- stall  out  1  issue_valid and not issue_ready.
- wb_valid  out  1  result ready for writeback.
- wb_ready  in  1  writeback accepted.
- wb_unit  out  2  0 mul, 1 div, 2 clmul.
- wb_waddr  out  5  pending destination.
- wb_wren  out  1  pending write enable.
- err  out  1  malformed-issue pulse.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, WB.
REQ-006 SHALL drive issue_ready = (state==IDLE) | (state==WB & wb_ready & !flush).
REQ-007 SHALL accept an issue only when issue_valid & issue_ready and exactly one unit flag is set; on accept, SHALL latch waddr, wren and unit, load a 6-bit counter with LAT-1 for the selected unit, pulse the matching unit_start bit in the same cycle, and enter RUN.
REQ-008 SHALL, when issue_valid & issue_ready and zero or more than one flag is set, not accept the issue, pulse err for one cycle and keep the current state-transition rule.
REQ-009 SHALL, in RUN, decrement the counter each cycle and move to WB in the cycle after the counter reads 0, giving RUN exactly LAT cycles and wb_valid first asserted LAT+1 cycles after the accept cycle.
REQ-010 SHALL hold wb_valid, wb_unit, wb_waddr and wb_wren stable in WB until wb_ready; on wb_ready, SHALL go to IDLE, or back to RUN when a new issue is accepted in the same cycle.
REQ-011 SHALL compute hazard = (state!=IDLE) & wb_wren & ((rden1 & raddr1==wb_waddr) | (rden2 & raddr2==wb_waddr)).
REQ-012 SHALL drive stall = issue_valid & !issue_ready.
REQ-013 SHALL treat flush in RUN or WB as follows: pulse unit_kill, go to IDLE next cycle, drop the pending result without a wb_valid handshake, and accept no issue in the flush cycle.
REQ-014 SHALL ignore flush in IDLE; unit_kill SHALL NOT pulse and an issue in that cycle SHALL NOT be accepted.
REQ-015 SHALL give flush priority over wb_ready when both are high in WB.

Reset
REQ-016 SHALL, on reset high at a clock edge, enter IDLE, clear the counter and latched fields, and take all outputs to 0 except issue_ready, which SHALL be 1 from the first post-reset cycle.
REQ-017 SHALL, on reset asserted mid-RUN or mid-WB, abandon the operation without a unit_kill pulse; units SHALL be reset by the same signal.

Structure
REQ-018 SHALL place the FSM state enum and the default latency constants in package constants.
REQ-019 SHALL place exec_sched_in_type and exec_sched_out_type structs in package wires.
REQ-020 SHALL factor the hazard comparison into one combinational sub-module, exec_hazard; the counter and FSM SHALL stay inline.

Verification
REQ-021 SHALL cover: mult issue with waddr=5 and wren=1 at cycle 0 -> unit_start=001 at cycle 0; wb_valid at cycle 4 with wb_unit=0 and wb_waddr=5.
REQ-022 SHALL cover: div issue, then wb_ready held low for 10 cycles after wb_valid -> outputs stable, stall=1 for a pending issue, and accept on the wb_ready cycle.
REQ-023 SHALL cover: clmul issue to waddr=7, younger op with rden2=1 and raddr2=7 during RUN -> hazard=1; with raddr2=8 -> hazard=0.
REQ-024 SHALL cover: flush in the 3rd RUN cycle of a div -> unit_kill=1 that cycle, IDLE next cycle, and no wb_valid.
REQ-025 SHALL cover: issue with mult=div=1 -> err pulse, issue_ready=1, state stays IDLE.
REQ-026 SHALL cover: reset asserted in WB -> all outputs 0 and issue_ready=1 next cycle.
